startup_link_ctrl: RTL and testbench
====================================

STARTUP_LINK_CTRL -- requirements
Module: startup_link_ctrl

Interface
REQ-001 Parameter WINDOW_CYCLES, default 500000: response window length in clk cycles (5 ms at 100 MHz).
REQ-002 Parameter TX_TIMEOUT, default 1600000: maximum cycles to wait for startup_compl.
REQ-003 Parameter DUTY_INIT, default 50: initial duty cycle in percent.
REQ-004 Parameter DUTY_STEP, default 5: duty increment per retry, in percent.
REQ-005 Parameter DUTY_MAX, default 100: duty ceiling in percent.
REQ-006 Parameter MAX_RETRIES, default 10: maximum number of duty steps.
REQ-007 clk  input  1  the single clock; all state changes on its rising edge.
REQ-008 nrst  input  1  reset, asynchronous and active-high: asserted when 1, despite the name.
REQ-009 enable  input  1  level; 1 = run the link startup, 0 = abort and return to idle.
REQ-010 startup_compl  input  1  from the startup-pattern sender; 1 = 1111 pattern fully sent.
REQ-011 rx_in  input  1  response line from the RX; asynchronous to clk.
REQ-012 data_start  output  1  enables the pattern sender.
REQ-013 startup_data  output  1  launch level to the pattern sender.
REQ-014 duty  output  7  current duty cycle in percent, range 0..100.
REQ-015 retry_cnt  output  4  number of duty steps taken; saturates at 15.
REQ-016 link_up  output  1  1 = RX response received.
REQ-017 fail  output  1  1 = startup abandoned.

Function
REQ-018 FSM states SHALL be IDLE, LAUNCH, WAIT_TX, LISTEN, STEP, LINKED, FAIL.
REQ-019 IDLE: duty=DUTY_INIT, retry_cnt=0; enable=1 -> LAUNCH on the next cycle.
REQ-020 LAUNCH SHALL last exactly one cycle -> WAIT_TX.
REQ-021 WAIT_TX: startup_compl=1 -> LISTEN, clearing the window and edge counters; TX_TIMEOUT cycles without startup_compl -> FAIL.
REQ-022 LISTEN SHALL count rising edges of the conditioned rx_in; the count reaching 4 -> LINKED on that cycle.
REQ-023 LISTEN SHALL go to STEP when the window counter reaches WINDOW_CYCLES-1 with fewer than 4 edges.
REQ-024 If the 4th edge and window expiry coincide, LINKED SHALL win.
REQ-025 STEP, one cycle: if duty+DUTY_STEP > DUTY_MAX or retry_cnt == MAX_RETRIES -> FAIL; else duty += DUTY_STEP, retry_cnt += 1 -> LAUNCH.
REQ-026 The duty add SHALL be computed 8 bits wide before the comparison, so it never wraps.
REQ-027 LINKED and FAIL SHALL hold until enable=0, then -> IDLE.
REQ-028 enable=0 in any state SHALL force IDLE on the next cycle, and the outputs SHALL take their IDLE values.
REQ-029 data_start=1 in LAUNCH, WAIT_TX, LISTEN, STEP and LINKED; 0 in IDLE and FAIL.
REQ-030 startup_data=1 in LAUNCH and WAIT_TX only, so it is low for at least one cycle (STEP) between attempts.
REQ-031 The pattern sender SHALL clear startup_compl while startup_data=0; this block samples startup_compl as a level.
REQ-032 link_up=1 only in LINKED; fail=1 only in FAIL; all outputs SHALL be registered.

Reset
REQ-033 While nrst=1: state=IDLE, duty=DUTY_INIT, retry_cnt=0, all counters 0, and data_start, startup_data, link_up and fail all 0.
REQ-034 Reset mid-attempt SHALL abandon the attempt immediately; after release the block waits in IDLE for enable.
REQ-035 The rx_in conditioning flops SHALL reset to 0, so a line already high at release is not counted as an edge.

Configuration
REQ-036 Macro STARTUP_RX_SYNC_EN: when defined, rx_in passes through a 2-flop synchronizer before edge detection, adding 2 cycles of edge latency.
REQ-037 When STARTUP_RX_SYNC_EN is undefined, rx_in feeds the edge detector directly through a single register; the FSM behaviour is otherwise identical.

Verification
Bench parameters: WINDOW_CYCLES=50, TX_TIMEOUT=200, DUTY_INIT=50, DUTY_STEP=5, DUTY_MAX=100, MAX_RETRIES=3.
REQ-038 enable=1, startup_compl at cycle 10, 4 rx_in pulses inside the window -> link_up=1, duty=50, retry_cnt=0, fail=0.
REQ-039 No rx_in activity on any attempt -> duty goes 50, 55, 60, 65 with retry_cnt 0..3, then fail=1 and data_start=0.
REQ-040 4th rx_in edge lands on window cycle 49 -> LINKED, not STEP; retry_cnt stays 0.
REQ-041 startup_compl never asserted -> fail=1 exactly 200 cycles after WAIT_TX is entered.
REQ-042 nrst=1 pulse during LISTEN, then enable=1 -> outputs at reset values during the pulse; a fresh attempt starts with duty=50.
REQ-043 DUTY_INIT=98, no response -> STEP goes to FAIL, duty stays 98 and never exceeds 100.

Source files
------------

// File: rtl/startup_link_ctrl.sv
// startup_link_ctrl: link startup FSM that relaunches the pattern sender with rising duty until the RX answers.
// Define STARTUP_RX_SYNC_EN to put a 2-flop synchronizer in front of the rx_in edge detector.
module startup_link_ctrl #(
  parameter int WINDOW_CYCLES = 500000,
  parameter int TX_TIMEOUT    = 1600000,
  parameter int DUTY_INIT     = 50,
  parameter int DUTY_STEP     = 5,
  parameter int DUTY_MAX      = 100,
  parameter int MAX_RETRIES   = 10
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       enable,
  input  logic       startup_compl,
  input  logic       rx_in,
  output logic       data_start,
  output logic       startup_data,
  output logic [6:0] duty,
  output logic [3:0] retry_cnt,
  output logic       link_up,
  output logic       fail
);
  localparam int TW = $clog2(TX_TIMEOUT + 1);
  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_TX, LISTEN, STEP, LINKED, FAIL} state_t;
  state_t state, nxt;
  logic [TW-1:0] tx_cnt;
  logic [WW-1:0] win_cnt;
  logic [2:0] edge_cnt, edge_nxt;
  logic rx_src, rx_r, rx_p, rise;
  logic [7:0] duty_sum;
  logic step_stop, bump;
  logic [6:0] duty_n;
  logic [3:0] retry_n;
  logic ds_n, sd_n, lu_n, fl_n;
`ifdef STARTUP_RX_SYNC_EN
  logic [1:0] rx_s;
  always_ff @(posedge clk or posedge nrst)
    if (nrst) rx_s <= '0;
    else rx_s <= {rx_s[0], rx_in};
  assign rx_src = rx_s[1];
`else
  assign rx_src = rx_in;
`endif
  // flops reset low so a line already high at release is not seen as an edge
  always_ff @(posedge clk or posedge nrst)
    if (nrst) {rx_p, rx_r} <= '0;
    else {rx_p, rx_r} <= {rx_r, rx_src};
  assign rise      = rx_r & ~rx_p;
  assign edge_nxt  = edge_cnt + 3'(rise);
  assign duty_sum  = {1'b0, duty} + 8'(DUTY_STEP);
  assign step_stop = duty_sum > 8'(DUTY_MAX) || retry_cnt == 4'(MAX_RETRIES);
  always_ff @(posedge clk or posedge nrst)
    if (nrst) begin
      state        <= IDLE;
      tx_cnt       <= '0;
      win_cnt      <= '0;
      edge_cnt     <= '0;
      duty         <= 7'(DUTY_INIT);
      retry_cnt    <= '0;
      data_start   <= 1'b0;
      startup_data <= 1'b0;
      link_up      <= 1'b0;
      fail         <= 1'b0;
    end else begin
      state        <= nxt;
      tx_cnt       <= state == WAIT_TX ? tx_cnt + TW'(1) : '0;
      win_cnt      <= state == LISTEN ? win_cnt + WW'(1) : '0;
      edge_cnt     <= state == LISTEN ? edge_nxt : '0;
      duty         <= duty_n;
      retry_cnt    <= retry_n;
      data_start   <= ds_n;
      startup_data <= sd_n;
      link_up      <= lu_n;
      fail         <= fl_n;
    end
  // the 4th edge is tested before window expiry so a coincident edge links
  always_comb begin
    nxt = state;
    if (!enable) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = LAUNCH;
        LAUNCH:  nxt = WAIT_TX;
        WAIT_TX: nxt = startup_compl ? LISTEN : tx_cnt == TW'(TX_TIMEOUT - 1) ? FAIL : WAIT_TX;
        LISTEN:  nxt = edge_nxt == 3'd4 ? LINKED : win_cnt == WW'(WINDOW_CYCLES - 1) ? STEP : LISTEN;
        STEP:    nxt = step_stop ? FAIL : LAUNCH;
        default: nxt = state;
      endcase
  end
  // outputs are decoded from the next state so the registered copies line up with state
  always_comb begin
    bump    = state == STEP && nxt == LAUNCH;
    duty_n  = nxt == IDLE ? 7'(DUTY_INIT) : bump ? duty_sum[6:0] : duty;
    retry_n = nxt == IDLE ? 4'd0 : bump && retry_cnt != 4'hf ? retry_cnt + 4'd1 : retry_cnt;
    ds_n    = nxt != IDLE && nxt != FAIL;
    sd_n    = nxt == LAUNCH || nxt == WAIT_TX;
    lu_n    = nxt == LINKED;
    fl_n    = nxt == FAIL;
  end
endmodule

// File: tb/tb_startup_link_ctrl.sv
// tb_startup_link_ctrl: stimulus queues expected launch/terminal events; a negedge monitor pops and checks them.
module tb_startup_link_ctrl;
  logic clk = 0, nrst = 1, enable = 0, en98 = 0, compl = 0, rx = 0;
  logic data_start, startup_data, link_up, fail;
  logic [6:0] duty;
  logic [3:0] retry_cnt;
  logic ds98, sd98, lu98, fl98;
  logic [6:0] duty98;
  logic [3:0] retry98;
  int n_cmp = 0, n_bad = 0, compl_delay = -1, sd_cnt = 0, cyc = 0, launch_cyc = 0, max98 = 0;
  logic sd_prev = 0, term_prev = 0;
`ifdef STARTUP_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  typedef struct { bit term; int link; int fl; int duty; int retry; int ds; int lat; } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  startup_link_ctrl #(.WINDOW_CYCLES(50), .TX_TIMEOUT(200), .DUTY_INIT(50), .DUTY_STEP(5),
    .DUTY_MAX(100), .MAX_RETRIES(3)) u_dut (
    .clk(clk), .nrst(nrst), .enable(enable), .startup_compl(compl), .rx_in(rx),
    .data_start(data_start), .startup_data(startup_data), .duty(duty), .retry_cnt(retry_cnt),
    .link_up(link_up), .fail(fail));
  startup_link_ctrl #(.WINDOW_CYCLES(50), .TX_TIMEOUT(200), .DUTY_INIT(98), .DUTY_STEP(5),
    .DUTY_MAX(100), .MAX_RETRIES(3)) u_dut98 (
    .clk(clk), .nrst(nrst), .enable(en98), .startup_compl(compl), .rx_in(rx),
    .data_start(ds98), .startup_data(sd98), .duty(duty98), .retry_cnt(retry98),
    .link_up(lu98), .fail(fl98));
  // pattern sender model: completes compl_delay cycles into startup_data, clears while it is low
  always @(negedge clk)
    if (!startup_data) begin
      compl = 0;
      sd_cnt = 0;
    end else begin
      sd_cnt++;
      if (compl_delay >= 0 && sd_cnt >= compl_delay) compl = 1;
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask
  task automatic observe(input bit term);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got %s event (duty=%0d retry=%0d) required none",
               term ? "terminal" : "launch", duty, retry_cnt);
      return;
    end
    e = q.pop_front();
    chk("event_kind", 32'(term), 32'(e.term));
    chk("duty", duty, e.duty);
    chk("retry_cnt", retry_cnt, e.retry);
    chk("data_start", data_start, e.ds);
    if (term) begin
      chk("link_up", link_up, e.link);
      chk("fail", fail, e.fl);
      if (e.lat >= 0) chk("fail_latency", cyc - launch_cyc, e.lat);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (startup_data && !sd_prev) begin
      launch_cyc = cyc;
      observe(1'b0);
    end
    if ((link_up || fail) && !term_prev) observe(1'b1);
    sd_prev = startup_data;
    term_prev = link_up || fail;
    if (int'(duty98) > max98) max98 = int'(duty98);
  end
  function automatic void exp_launch(input int d, input int r);
    q.push_back('{1'b0, 0, 0, d, r, 1, -1});
  endfunction
  function automatic void exp_term(input int lk, input int fl, input int d, input int r, input int ds, input int lat);
    q.push_back('{1'b1, lk, fl, d, r, ds, lat});
  endfunction
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0d events still pending required 0", name, q.size());
      q.delete();
    end
  endtask
  task automatic wait_compl(input string name);
    int i;
    i = 0;
    do begin
      @(posedge clk);
      i++;
    end while (!compl && i < 400);
    if (!compl) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got startup_compl=0 after 400 cycles required 1", name);
    end
  endtask
  // mask bit j set = rising edge seen by the FSM in listen-window cycle j
  task automatic drive_rx(input logic [63:0] mask);
    for (int k = 0; k < 55 - LAT; k++) begin
      @(negedge clk);
      rx = mask[k + 1 + LAT];
    end
    rx = 0;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_data_start"}, data_start, 0);
    chk({tag, "_startup_data"}, startup_data, 0);
    chk({tag, "_duty"}, duty, 50);
    chk({tag, "_retry"}, retry_cnt, 0);
    chk({tag, "_link_up"}, link_up, 0);
    chk({tag, "_fail"}, fail, 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by 300000 time units required finish");
    $fatal(1);
  end
  initial begin
    tick(3);
    chk_idle("rst");
    nrst = 0;
    tick(2);
    compl_delay = 10;
    exp_launch(50, 0);
    exp_term(1, 0, 50, 0, 1, -1);
    enable = 1;
    wait_compl("t1_compl");
    drive_rx(64'h0000_0000_0003_3330);
    wait_drain("t1_link", 200);
    tick(3);
    chk("t1_link_hold", link_up, 1);
    enable = 0;
    tick(2);
    chk_idle("t1_abort");
    compl_delay = 3;
    exp_launch(50, 0);
    exp_launch(55, 1);
    exp_launch(60, 2);
    exp_launch(65, 3);
    exp_term(0, 1, 65, 3, 0, -1);
    enable = 1;
    en98 = 1;
    wait_drain("t2_retries", 1000);
    tick(5);
    chk("t2_fail_hold", fail, 1);
    chk("t2_ds_in_fail", data_start, 0);
    chk("t98_fail", fl98, 1);
    chk("t98_duty", duty98, 98);
    chk("t98_retry", retry98, 0);
    chk("t98_duty_max", max98, 98);
    chk("t98_data_start", ds98, 0);
    chk("t98_startup_data", sd98, 0);
    chk("t98_link_up", lu98, 0);
    enable = 0;
    en98 = 0;
    tick(2);
    chk_idle("t2_abort");
    compl_delay = 10;
    exp_launch(50, 0);
    exp_term(1, 0, 50, 0, 1, -1);
    enable = 1;
    wait_compl("t3_compl");
    drive_rx(64'h0006_0000_C030_0C00);
    wait_drain("t3_edge_at_expiry", 100);
    chk("t3_retry", retry_cnt, 0);
    enable = 0;
    tick(2);
    compl_delay = -1;
    exp_launch(50, 0);
    exp_term(0, 1, 50, 0, 0, 201);
    enable = 1;
    wait_drain("t4_timeout", 400);
    enable = 0;
    tick(2);
    compl_delay = 3;
    exp_launch(50, 0);
    exp_launch(55, 1);
    enable = 1;
    wait_drain("t5_pre", 300);
    wait_compl("t5_compl");
    tick(5);
    nrst = 1;
    enable = 0;
    tick(1);
    chk_idle("t5_rst");
    tick(1);
    nrst = 0;
    tick(3);
    chk("t5_idle_ds", data_start, 0);
    chk("t5_idle_duty", duty, 50);
    exp_launch(50, 0);
    enable = 1;
    wait_drain("t5_relaunch", 20);
    chk("t5_relaunch_sd", startup_data, 1);
    enable = 0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
